// File: rtl/handshake_pkg.sv
// handshake_pkg: shared widths and buffer entry type for the round-robin merge.
package handshake_pkg;
  localparam int N_REQ = 3;
  localparam int WIDTH = 4;
  localparam int ID_W = $clog2(N_REQ);
  typedef struct packed {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [ID_W-1:0]  id;
  } merge_entry_t;
endpackage

// File: rtl/handshake_skid2.sv
// handshake_skid2: 2-entry registered FIFO over merge_entry_t.
module handshake_skid2
  import handshake_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  merge_entry_t din,
  output logic         space,
  output merge_entry_t head,
  output logic [1:0]   count
);
  merge_entry_t e0, e1;
  logic wr, rd;
  assign space = count < 2'd2;
  assign wr = push & space;
  assign rd = pop & (count != 2'd0);
  assign head = e0;
  // e0 is always the head; a write lands in the first slot left free after any pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      if (rd) e0 <= e1;
      if (wr && (count - {1'b0, rd}) == 2'd0) e0 <= din;
      if (wr && (count - {1'b0, rd}) == 2'd1) e1 <= din;
      count <= count + {1'b0, wr} - {1'b0, rd};
    end
  end
endmodule

// File: rtl/handshake_rr_merge.sv
// handshake_rr_merge: round-robin merge of N_REQ ready/valid streams into one
// stream through a registered 2-entry buffer, tagging each beat with its source.
module handshake_rr_merge
  import handshake_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_in1,
  input  logic [N_REQ*WIDTH-1:0] req_in2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_in1,
  output logic [WIDTH-1:0]       out_in2,
  output logic [ID_W-1:0]        out_id,
  output logic [1:0]             occupancy
);
  logic [ID_W-1:0] rr_ptr, g, idx;
  logic [ID_W:0] sum;
  logic hit, space, push;
  logic [1:0] count;
  merge_entry_t head, din;
  // descending scan so the last hit is the one closest to rr_ptr
  always_comb begin
    g = '0;
    hit = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      idx = sum >= (ID_W+1)'(N_REQ) ? ID_W'(sum - (ID_W+1)'(N_REQ)) : ID_W'(sum);
      if (req_valid[idx]) begin
        g = idx;
        hit = 1'b1;
      end
    end
    req_ready = '0;
    if (space && hit && !RESET) req_ready[g] = 1'b1;
  end
  assign push = |(req_valid & req_ready);
  assign din = {req_in1[int'(g)*WIDTH +: WIDTH], req_in2[int'(g)*WIDTH +: WIDTH], g};
  always_ff @(posedge CLK) begin
    if (RESET) rr_ptr <= '0;
    else if (push) rr_ptr <= g == ID_W'(N_REQ - 1) ? '0 : g + 1'b1;
  end
  handshake_skid2 u_buf (
    .clk(CLK),
    .rst(RESET),
    .push(push),
    .pop(out_valid & out_ready),
    .din(din),
    .space(space),
    .head(head),
    .count(count)
  );
  assign out_valid = count != 2'd0;
  assign out_in1 = head.in1;
  assign out_in2 = head.in2;
  assign out_id = head.id;
  assign occupancy = count;
endmodule

// File: tb/tb_handshake_rr_merge.sv
// tb_handshake_rr_merge: directed vectors with hand-computed expectations.
module tb_handshake_rr_merge;
  logic CLK, RESET, out_ready, out_valid;
  logic [2:0] req_valid, req_ready;
  logic [11:0] req_in1, req_in2;
  logic [3:0] out_in1, out_in2;
  logic [1:0] out_id, occupancy;
  int n_tests = 0, n_fail = 0;

  handshake_rr_merge dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .out_valid(out_valid), .out_ready(out_ready),
    .out_in1(out_in1), .out_in2(out_in2), .out_id(out_id), .occupancy(occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    step();
    RESET = 1'b0;
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    req_valid = 3'b111;
    out_ready = 1'b0;
    req_in1 = {4'h3, 4'h2, 4'h1};
    req_in2 = {4'hC, 4'hB, 4'hA};
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_ready", req_ready, 3'b000);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_occ", occupancy, 2'd0);
      step();
    end
    RESET = 1'b0;
    #1;
    chk("first_grant", req_ready, 3'b001);
    req_valid = '0;
    out_ready = 1'b1;
    #1;
    chk("idle_ready", req_ready, 3'b000);

    req_in1 = {4'h0, 4'hA, 4'h0};
    req_in2 = {4'h0, 4'h3, 4'h0};
    req_valid = 3'b010;
    #1;
    chk("single_grant", req_ready, 3'b010);
    step();
    chk("single_valid", out_valid, 1'b1);
    chk("single_in1", out_in1, 4'hA);
    chk("single_in2", out_in2, 4'h3);
    chk("single_id", out_id, 2'd1);
    req_in1 = {4'h0, 4'hB, 4'h0};
    req_in2 = {4'h0, 4'h4, 4'h0};
    step();
    chk("single_in1_b2", out_in1, 4'hB);
    chk("single_in2_b2", out_in2, 4'h4);
    chk("single_occ", occupancy, 2'd1);
    req_valid = '0;
    step();
    chk("single_drain", out_valid, 1'b0);

    do_reset();
    req_in1 = {4'h3, 4'h2, 4'h1};
    req_in2 = {4'hC, 4'hB, 4'hA};
    req_valid = 3'b111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_id", out_id, k % 3);
      chk("rr_in1", out_in1, k % 3 + 1);
      chk("rr_in2", out_in2, k % 3 + 32'hA);
    end

    do_reset();
    req_valid = 3'b111;
    out_ready = 1'b0;
    step();
    step();
    chk("bp_occ", occupancy, 2'd2);
    chk("bp_ready", req_ready, 3'b000);
    chk("bp_id", out_id, 2'd0);
    step();
    chk("bp_hold_occ", occupancy, 2'd2);
    chk("bp_hold_id", out_id, 2'd0);
    chk("bp_hold_in1", out_in1, 4'h1);
    out_ready = 1'b1;
    #1;
    chk("bp_pop_noready", req_ready, 3'b000);
    step();
    out_ready = 1'b0;
    #1;
    chk("bp_bubble_occ", occupancy, 2'd1);
    chk("bp_next_id", out_id, 2'd1);
    chk("bp_grant2", req_ready, 3'b100);
    step();
    chk("bp_refill", occupancy, 2'd2);

    req_valid = 3'b101;
    out_ready = 1'b1;
    step();
    chk("wrap_grant0", req_ready, 3'b001);
    chk("wrap_head2", out_id, 2'd2);
    step();
    chk("wrap_out0", out_id, 2'd0);
    chk("wrap_grant2", req_ready, 3'b100);
    step();
    chk("wrap_out2", out_id, 2'd2);

    out_ready = 1'b0;
    req_valid = 3'b111;
    step();
    chk("mid_occ_full", occupancy, 2'd2);
    RESET = 1'b1;
    #1;
    chk("mid_rst_ready", req_ready, 3'b000);
    step();
    RESET = 1'b0;
    #1;
    chk("mid_occ", occupancy, 2'd0);
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_ptr", req_ready, 3'b001);
    req_valid = '0;
    out_ready = 1'b1;
    step();
    chk("mid_no_stale", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
